// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU fetch/data request ports and the shared single-port memory bus
interface mem_port_arbiter_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10
);
  logic                 i_req, i_flush, i_ack;
  logic [ADDR_SIZE-1:0] i_addr;
  logic [DATA_SIZE-1:0] i_rdata;
  logic                 d_req, d_we, d_ack;
  logic [ADDR_SIZE-1:0] d_addr;
  logic [DATA_SIZE-1:0] d_wdata, d_rdata;
  logic [ADDR_SIZE-1:0] m_addr;
  logic [DATA_SIZE-1:0] m_wdata, m_rdata;
  logic                 m_re, m_we, stall;
  modport master (
    output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_addr, m_wdata, m_re, m_we, stall
  );
  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_addr, m_wdata, m_re, m_we, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, data-first with a bounded data burst
module mem_port_arbiter #(
  parameter int DATA_SIZE   = 32,
  parameter int ADDR_SIZE   = 10,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_D_BURST = 2
) (
  input logic CLK,
  input logic RESET_N,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic owner_i, we, cancel, grant, pick_i, kill;
  logic [2:0] dburst, cnt;
  logic [ADDR_SIZE-1:0] addr_sel;
  logic [DATA_SIZE-1:0] rdata_q;
  assign bus.stall = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);
  always_comb begin
    grant    = state == IDLE && (bus.i_req || bus.d_req);
    pick_i   = bus.i_req && (!bus.d_req || dburst == 3'(MAX_D_BURST));
    addr_sel = pick_i ? bus.i_addr : bus.d_addr;
    kill     = cancel || bus.i_flush;
    state_nx = grant ? ISSUE :
               state == ISSUE ? WAIT :
               (state == WAIT && cnt == 3'd1) ? RESP :
               state == RESP ? IDLE : state;
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      owner_i     <= 1'b0;
      we          <= 1'b0;
      cancel      <= 1'b0;
      dburst      <= '0;
      cnt         <= '0;
      rdata_q     <= '0;
      bus.m_re    <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.i_ack   <= 1'b0;
      bus.d_ack   <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      bus.m_re  <= grant && (pick_i || !bus.d_we);
      bus.m_we  <= grant && !pick_i && bus.d_we;
      bus.i_ack <= state == RESP && owner_i && !kill;
      bus.d_ack <= state == RESP && !owner_i;
      // a flush during the RESP cycle itself is caught through kill, so cancel only needs to live until RESP
      cancel    <= (state == ISSUE || state == WAIT) && (cancel || (owner_i && bus.i_flush));
      cnt       <= state == ISSUE ? 3'(MEM_LATENCY) : state == WAIT ? cnt - 3'd1 : cnt;
      if (state == WAIT && cnt == 3'd1) rdata_q <= bus.m_rdata;
      if (grant) begin
        owner_i     <= pick_i;
        we          <= !pick_i && bus.d_we;
        bus.m_addr  <= addr_sel;
        bus.m_wdata <= bus.d_wdata;
        dburst      <= (pick_i || !bus.i_req) ? 3'd0 :
                       dburst == 3'(MAX_D_BURST) ? dburst : dburst + 3'd1;
      end
      if (state == RESP && owner_i && !kill) bus.i_rdata <= rdata_q;
      if (state == RESP && !owner_i && !we) bus.d_rdata <= rdata_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests against a transaction-timing model of the arbiter
module tb_mem_port_arbiter;
  localparam int DW = 32, AW = 10, L = 1, L4 = 4, MB = 2;
  logic CLK = 1'b0, RESET_N = 1'b0;
  always #5 CLK = ~CLK;
  mem_port_arbiter_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();
  mem_port_arbiter_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus4 ();
  mem_port_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .MEM_LATENCY(L), .MAX_D_BURST(MB))
    dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));
  mem_port_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .MEM_LATENCY(L4), .MAX_D_BURST(MB))
    dut4 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus4));
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // memory: strobe seen in the ISSUE cycle, data valid only in the L-th cycle after it, junk otherwise
  logic [DW-1:0] mem [1<<AW];
  int rd_left = 0, rd4_left = 0;
  logic [AW-1:0] rd_addr, rd4_addr;
  always @(negedge CLK) begin
    if (!RESET_N) rd_left = 0;
    else if (bus.m_re) begin rd_left = L + 1; rd_addr = bus.m_addr; end
    else if (rd_left > 0) rd_left--;
    if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
    bus.m_rdata = rd_left == 1 ? mem[rd_addr] : 32'hBAD0_0000 | 32'(rd_left);
  end
  always @(negedge CLK) begin
    if (!RESET_N) rd4_left = 0;
    else if (bus4.m_re) begin rd4_left = L4 + 1; rd4_addr = bus4.m_addr; end
    else if (rd4_left > 0) rd4_left--;
    bus4.m_rdata = rd4_left == 1 ? mem[rd4_addr] : 32'hBAD4_0000 | 32'(rd4_left);
  end
  // model: one transaction at a time, issue in cycle g, ack in cycle g+L+2, next grant at edge g+L+3
  int cyc = 0, g = 0, free_at = 0, dburst = 0;
  bit t_act, t_i, t_we, t_cancel, e_iack, e_dack;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, e_irdata = '0, e_drdata = '0;
  string order = "";
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      t_act = 0; e_iack = 0; e_dack = 0; e_irdata = '0; e_drdata = '0; dburst = 0; free_at = 0;
    end else begin
      cyc++;
      e_iack = 0;
      e_dack = 0;
      if (t_act && t_i && bus.i_flush && cyc > g && cyc <= g + L + 2) t_cancel = 1;
      if (t_act && cyc == g + L + 2) begin
        if (t_i && !t_cancel) begin e_iack = 1; e_irdata = mem[t_addr]; end
        if (!t_i) begin e_dack = 1; if (!t_we) e_drdata = mem[t_addr]; end
        t_act = 0;
        free_at = cyc + 1;
      end
      if (!t_act && cyc >= free_at && (bus.i_req || bus.d_req)) begin
        t_i = bus.i_req && (!bus.d_req || dburst == MB);
        dburst = (t_i || !bus.i_req) ? 0 : (dburst < MB ? dburst + 1 : dburst);
        t_we = !t_i && bus.d_we;
        t_addr = t_i ? bus.i_addr : bus.d_addr;
        t_wdata = bus.d_wdata;
        t_act = 1; t_cancel = 0; g = cyc;
        if (t_i) order = {order, "I"}; else order = {order, "D"};
      end
    end
  end
  always @(negedge CLK) begin
    logic x_re, x_we;
    x_re = t_act && cyc == g && !t_we;
    x_we = t_act && cyc == g && t_we;
    chk("m_re", bus.m_re, x_re);
    chk("m_we", bus.m_we, x_we);
    chk("i_ack", bus.i_ack, e_iack);
    chk("d_ack", bus.d_ack, e_dack);
    chk("i_rdata", bus.i_rdata, e_irdata);
    chk("d_rdata", bus.d_rdata, e_drdata);
    chk("stall", bus.stall, (bus.i_req & ~e_iack) | (bus.d_req & ~e_dack));
    if (x_re || x_we) chk("m_addr", bus.m_addr, t_addr);
    if (x_we) chk("m_wdata", bus.m_wdata, t_wdata);
  end
  logic iss_re, iss_we;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_wdata;
  // request already driven; grant on the next edge, returns cycles from grant to ack (-1 if none)
  task automatic run(input bit is_i, input bit scr, output int k);
    k = -1;
    @(posedge CLK);
    for (int n = 0; n < 20 && k < 0; n++) begin
      @(negedge CLK);
      if (n == 0) begin iss_re = bus.m_re; iss_we = bus.m_we; iss_addr = bus.m_addr; iss_wdata = bus.m_wdata; end
      if (is_i ? bus.i_ack : bus.d_ack) begin
        k = n;
        #1;
        if (is_i) bus.i_req = 0; else bus.d_req = 0;
      end else if (n == 0 && scr) begin
        #1 bus.d_addr = ~bus.d_addr; bus.d_wdata = ~bus.d_wdata; bus.d_we = ~bus.d_we;
      end
    end
  endtask
  initial begin
    int k, nre, iacks, lowst, ostart;
    string dorder;
    bus.i_req = 0; bus.i_flush = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus4.i_req = 0; bus4.i_flush = 0; bus4.i_addr = '0; bus4.d_req = 0; bus4.d_we = 0; bus4.d_addr = '0; bus4.d_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA5A5_0000 + 32'(i);
    mem[5] = 32'h0050_0093;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_m_re", bus.m_re, 0);
    chk("rst_i_ack", bus.i_ack, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    @(posedge CLK); #1 RESET_N = 1;
    bus4.d_req = 1; bus4.d_addr = 2;
    @(posedge CLK);
    k = -1; nre = 0;
    for (int n = 0; n < 20 && k < 0; n++) begin
      @(negedge CLK);
      nre += int'(bus4.m_re);
      if (bus4.d_ack) begin k = n; #1 bus4.d_req = 0; end
    end
    chk("lat4_ack_cycle", k, 6);
    chk("lat4_m_re_cycles", nre, 1);
    chk("lat4_rdata", bus4.d_rdata, 32'hA5A5_0002);
    @(posedge CLK); #1 bus.i_req = 1; bus.i_addr = 5;
    run(1, 0, k);
    chk("fetch_m_re", iss_re, 1);
    chk("fetch_m_addr", iss_addr, 5);
    chk("fetch_ack_cycle", k, 3);
    chk("fetch_rdata", bus.i_rdata, 32'h0050_0093);
    @(posedge CLK); #1 bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9;
    run(0, 0, k);
    chk("load_ack_cycle", k, 3);
    chk("load_rdata", bus.d_rdata, 32'hA5A5_0009);
    @(posedge CLK); #1 bus.d_req = 1; bus.d_we = 1; bus.d_addr = 3; bus.d_wdata = 32'hDEAD_BEEF;
    run(0, 1, k);
    chk("store_m_we", iss_we, 1);
    chk("store_m_re", iss_re, 0);
    chk("store_m_addr", iss_addr, 3);
    chk("store_m_wdata", iss_wdata, 32'hDEAD_BEEF);
    chk("store_ack_cycle", k, 3);
    chk("store_d_rdata_kept", bus.d_rdata, 32'hA5A5_0009);
    @(posedge CLK); #1 bus.d_req = 1; bus.d_we = 0; bus.d_addr = 3;
    run(0, 0, k);
    chk("reload_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    @(posedge CLK); #1 bus.i_req = 1; bus.i_addr = 7;
    @(posedge CLK);
    @(posedge CLK); #1 bus.i_flush = 1; bus.i_req = 0;
    @(posedge CLK); #1 bus.i_flush = 0;
    nre = 0;
    repeat (5) begin @(negedge CLK); nre += int'(bus.i_ack); end
    chk("flush_no_ack", nre, 0);
    chk("flush_rdata_kept", bus.i_rdata, 32'h0050_0093);
    @(posedge CLK); #1 bus.i_req = 1; bus.i_addr = 8;
    run(1, 0, k);
    chk("after_flush_ack_cycle", k, 3);
    chk("after_flush_rdata", bus.i_rdata, 32'hA5A5_0008);
    @(posedge CLK); #1 bus.i_req = 1; bus.i_addr = 5; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9;
    ostart = order.len(); dorder = ""; iacks = 0; lowst = 0;
    for (int n = 0; n < 60 && iacks < 2; n++) begin
      @(negedge CLK);
      if (bus.m_re) begin if (bus.m_addr == 10'd5) dorder = {dorder, "I"}; else dorder = {dorder, "D"}; end
      if (iacks == 0 && !bus.i_ack && !bus.stall) lowst++;
      if (bus.i_ack) begin
        iacks++;
        if (iacks == 2) begin #1 bus.i_req = 0; bus.d_req = 0; end
      end
    end
    chk("arb_dut_order", dorder == "DDIDDI", 1);
    chk("arb_model_order", order.substr(ostart, ostart + 5) == "DDIDDI", 1);
    chk("arb_stall_held", lowst, 0);
    @(posedge CLK); #1 bus.d_req = 1; bus.d_we = 0; bus.d_addr = 4;
    @(posedge CLK);
    @(posedge CLK); #2 RESET_N = 0;
    #1;
    chk("rst_mid_m_addr", bus.m_addr, 0);
    chk("rst_mid_d_rdata", bus.d_rdata, 0);
    chk("rst_mid_i_rdata", bus.i_rdata, 0);
    chk("rst_mid_d_ack", bus.d_ack, 0);
    @(posedge CLK); #1 RESET_N = 1;
    run(0, 0, k);
    chk("rst_regrant_ack_cycle", k, 3);
    chk("rst_regrant_rdata", bus.d_rdata, 32'hA5A5_0004);
    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 32, data width of all data buses.
REQ-002 Parameter ADDR_SIZE, default 10, word-address width of all address buses.
REQ-003 Parameter MEM_LATENCY, default 1, legal 1..4, cycles from the memory sampling a strobe to valid m_rdata.
REQ-004 Parameter MAX_D_BURST, default 2, legal 1..7, consecutive data grants allowed while i_req is pending.
REQ-005 CLK  input  1  clock, rising edge.
REQ-006 RESET_N  input  1  asynchronous, active-low reset.
REQ-007 i_req  input  1  instruction-fetch request, held until i_ack.
REQ-008 i_addr  input  ADDR_SIZE  fetch word address.
REQ-009 i_flush  input  1  cancels the in-flight fetch response (taken branch).
REQ-010 i_ack  output  1  one-cycle fetch completion pulse.
REQ-011 i_rdata  output  DATA_SIZE  fetched word, valid with i_ack, held until the next i_ack.
REQ-012 d_req  input  1  data request, held until d_ack.
REQ-013 d_we  input  1  1 = store, 0 = load.
REQ-014 d_addr  input  ADDR_SIZE  data word address.
REQ-015 d_wdata  input  DATA_SIZE  store data.
REQ-016 d_ack  output  1  one-cycle data completion pulse.
REQ-017 d_rdata  output  DATA_SIZE  load data, valid with d_ack, held until the next load d_ack.
REQ-018 m_addr, m_wdata  output  ADDR_SIZE, DATA_SIZE  shared single-port memory address and write data, registered.
REQ-019 m_re, m_we  output  1 each  memory read and write strobes, registered.
REQ-020 m_rdata  input  DATA_SIZE  memory read data.
REQ-021 stall  output  1  combinational: (i_req & ~i_ack) | (d_req & ~d_ack).

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, RESP; the current owner (I or D) is latched on grant.
REQ-023 IDLE: on the edge where any request is sampled, grant, latch owner, address, we and wdata, and go to ISSUE; with no request, stay in IDLE.
REQ-024 Arbitration: data wins over instruction, except that instruction wins when i_req=1 and dburst==MAX_D_BURST.
REQ-025 dburst counter (3 bits): increments on each data grant made while i_req=1; clears on any instruction grant and whenever i_req=0 at a grant; saturates at MAX_D_BURST.
REQ-026 ISSUE: exactly one cycle with m_re=~we or m_we=we and m_addr/m_wdata = latched values; counter loaded with MEM_LATENCY.
REQ-027 WAIT: counter decrements each cycle; on the edge where it reaches 0, capture m_rdata and go to RESP; m_re=m_we=0 in WAIT.
REQ-028 RESP: one cycle; pulse the owner's ack; load data goes to the owner's rdata register; store leaves d_rdata unchanged; next state IDLE.
REQ-029 Latency: ack is high in the cycle that begins MEM_LATENCY+2 edges after the request-sampling edge; a back-to-back transaction takes MEM_LATENCY+3 cycles.
REQ-030 No request is accepted in ISSUE, WAIT or RESP.
REQ-031 Changes to address, we or wdata after the grant are ignored.
REQ-032 A request dropped before its ack still completes its memory access, and its ack still pulses.
REQ-033 i_flush high in any cycle while the owner is I and the state is ISSUE, WAIT or RESP sets a sticky cancel bit.
REQ-034 When the cancel bit is set, the fetch still completes in memory, i_ack is suppressed, i_rdata is unchanged, and the bit clears on return to IDLE.
REQ-035 i_flush has no effect on data transactions or in IDLE.
REQ-036 Simultaneous i_req and d_req in IDLE: exactly one grant per REQ-024; the loser stays pending with stall=1.
REQ-037 m_re and m_we are never high together, and never high outside ISSUE.

Reset
REQ-038 RESET_N low asynchronously forces IDLE; owner, cancel and dburst to 0; m_re, m_we, i_ack and d_ack to 0; m_addr, m_wdata, i_rdata and d_rdata to 0.
REQ-039 Reset mid-transaction discards the transaction with no ack; the first grant after release follows REQ-023.

Verification
REQ-040 MEM_LATENCY=1: i_req, i_addr=5, m_rdata returns 0x00500093 -> m_re plus m_addr=5 for one cycle, then i_ack and i_rdata=0x00500093 in the third cycle after the sampling edge.
REQ-041 i_req and d_req (load, addr 9) both high, MAX_D_BURST=2, d_req re-asserted after each ack -> grant order D, D, I, D, D, I; stall stays 1 until i_ack.
REQ-042 Store d_addr=3, d_wdata=0xDEADBEEF -> one cycle of m_we=1, m_addr=3, m_wdata=0xDEADBEEF, m_re=0; d_ack pulses; d_rdata unchanged.
REQ-043 Fetch in flight, i_flush pulsed in WAIT -> no i_ack, i_rdata keeps its previous value, FSM returns to IDLE and a new i_req is served normally.
REQ-044 RESET_N low during WAIT of a load -> all outputs 0 immediately, no d_ack; after release the held d_req is granted and acked normally.
REQ-045 MEM_LATENCY=4: single load -> ack high in the cycle beginning 6 edges after the sampling edge; m_re high in exactly one cycle.
